// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file and its writeback path.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    logic      we;
    reg_addr_t a3;
    xlen_t     wd3;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward (mod N), first requester wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]               req,
  input  logic [$clog2(N)-1:0]       ptr,
  output logic [N-1:0]               gnt,
  output logic [$clog2(N)-1:0]       gnt_idx
);

  localparam int IW = $clog2(N);

  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[IW'(idx)]) begin
        found             = 1'b1;
        gnt[IW'(idx)]     = 1'b1;
        gnt_idx           = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the regfile write port plus a busy scoreboard for RAW stalls.
// Optional arbitration-loss counter is built only when WB_PERF_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][AW-1:0]    req_rd,
  input  logic [N_REQ-1:0][XLEN-1:0]  req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        alloc_en,
  input  logic [AW-1:0]               alloc_rd,
  output logic [NREG-1:0]             busy,
  output logic                        wb_we,
  output logic [AW-1:0]               wb_a3,
  output logic [XLEN-1:0]             wb_wd3,
  output logic [31:0]                 stall_cnt
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]    rr_ptr_reg;
  logic [IW-1:0]    gnt_idx;
  logic             any_gnt;
  wb_req_t          wb_reg;
  logic [NREG-1:1]  busy_reg;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_reg),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt = |req_ready;

  // Writes to x0 still consume a grant but are presented with we low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_reg <= IW'(N_REQ - 1);
      wb_reg     <= '0;
    end else if (any_gnt) begin
      rr_ptr_reg <= gnt_idx;
      wb_reg.we  <= (req_rd[gnt_idx] != '0);
      wb_reg.a3  <= req_rd[gnt_idx];
      wb_reg.wd3 <= req_data[gnt_idx];
    end else begin
      wb_reg.we  <= 1'b0;
    end
  end

  assign wb_we  = wb_reg.we;
  assign wb_a3  = wb_reg.a3;
  assign wb_wd3 = wb_reg.wd3;

  // Set has priority over clear: a same-edge allocation is a newer pending write.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_busy
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          busy_reg[gi] <= 1'b0;
        end else if (alloc_en && (alloc_rd == AW'(gi))) begin
          busy_reg[gi] <= 1'b1;
        end else if (wb_reg.we && (wb_reg.a3 == AW'(gi))) begin
          busy_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign busy = {busy_reg, 1'b0};

`ifdef WB_PERF_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (|(req_valid & ~req_ready) && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with three requesters and a small regfile model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N-1:0]            req_valid;
  logic [N-1:0][AW-1:0]    req_rd;
  logic [N-1:0][XLEN-1:0]  req_data;
  logic [N-1:0]            req_ready;
  logic                    alloc_en;
  logic [AW-1:0]           alloc_rd;
  logic [NREG-1:0]         busy;
  logic                    wb_we;
  logic [AW-1:0]           wb_a3;
  logic [XLEN-1:0]         wb_wd3;
  logic [31:0]             stall_cnt;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] rf [NREG];

  regfile_wb_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .alloc_en  (alloc_en),
    .alloc_rd  (alloc_rd),
    .busy      (busy),
    .wb_we     (wb_we),
    .wb_a3     (wb_a3),
    .wb_wd3    (wb_wd3),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wb_we) rf[wb_a3] <= wb_wd3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t wb_we=%0b a3=%0d wd3=%08h busy=%08h stall=%0d",
             $time, wb_we, wb_a3, wb_wd3, busy, stall_cnt);
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    alloc_en  = 1'b0;
    alloc_rd  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", wb_we); end
    checks++; if (wb_a3 !== '0) begin failures++; $display("FAIL reset_a3 got=%0d exp=0", wb_a3); end
    checks++; if (wb_wd3 !== '0) begin failures++; $display("FAIL reset_wd3 got=%h exp=0", wb_wd3); end
    checks++; if (busy !== '0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    checks++; if (req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_single();
    alloc_en = 1'b1; alloc_rd = 5'd5;
    tick();
    alloc_en = 1'b0;
    checks++; if (busy !== (32'h1 << 5)) begin failures++; $display("FAIL single_busy_set got=%h exp=%h", busy, 32'h1 << 5); end
    req_valid = 3'b001; req_rd[0] = 5'd5; req_data[0] = 32'hDEAD_BEEF;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL single_wb got=%0b/%0d/%h exp=1/5/deadbeef", wb_we, wb_a3, wb_wd3);
    end
    checks++; if (busy[5] !== 1'b1) begin failures++; $display("FAIL single_busy_hold got=%0b exp=1", busy[5]); end
    tick();
    checks++; if (busy !== '0) begin failures++; $display("FAIL single_busy_clr got=%h exp=0", busy); end
    checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL single_hold got=%0b/%0d/%h exp=0/5/deadbeef", wb_we, wb_a3, wb_wd3);
    end
    checks++; if (rf[5] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rf got=%h exp=deadbeef", rf[5]); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_gnt [4];
    logic [N-1:0] exp3 [3];
    int           g;
    exp_gnt[0] = 3'b001; exp_gnt[1] = 3'b010; exp_gnt[2] = 3'b001; exp_gnt[3] = 3'b010;
    apply_reset();
    req_valid = 3'b011;
    req_rd[0] = 5'd1; req_data[0] = 32'hA0;
    req_rd[1] = 5'd2; req_data[1] = 32'hB1;
    req_rd[2] = 5'd4; req_data[2] = 32'hC2;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== exp_gnt[i]) begin failures++; $display("FAIL cont_gnt%0d got=%b exp=%b", i, req_ready, exp_gnt[i]); end
      tick();
      g = (exp_gnt[i] == 3'b001) ? 0 : 1;
      checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b1, req_rd[g], req_data[g]}) begin
        failures++; $display("FAIL cont_wb%0d got=%0b/%0d/%h exp=1/%0d/%h", i, wb_we, wb_a3, wb_wd3, req_rd[g], req_data[g]);
      end
`ifdef WB_PERF_EN
      checks++; if (stall_cnt !== 32'(i + 1)) begin failures++; $display("FAIL cont_stall%0d got=%0d exp=%0d", i, stall_cnt, i + 1); end
`else
      checks++; if (stall_cnt !== 32'h0) begin failures++; $display("FAIL cont_stall%0d got=%0d exp=0", i, stall_cnt); end
`endif
    end
    // Last grant went to req1, so with all three valid the order is 2,0,1.
    exp3[0] = 3'b100; exp3[1] = 3'b001; exp3[2] = 3'b010;
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== exp3[i]) begin failures++; $display("FAIL rr3_gnt%0d got=%b exp=%b", i, req_ready, exp3[i]); end
      tick();
    end
    checks++; if (wb_a3 !== 5'd2) begin failures++; $display("FAIL rr3_a3 got=%0d exp=2", wb_a3); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_x0();
    req_valid = 3'b010; req_rd[1] = 5'd0; req_data[1] = 32'h1234;
    rf[0] = 32'h0;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
    tick();
    req_valid = '0;
    checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b0, 5'd0, 32'h1234}) begin
      failures++; $display("FAIL x0_wb got=%0b/%0d/%h exp=0/0/1234", wb_we, wb_a3, wb_wd3);
    end
    tick();
    checks++; if (busy !== '0) begin failures++; $display("FAIL x0_busy got=%h exp=0", busy); end
    checks++; if (rf[0] !== 32'h0) begin failures++; $display("FAIL x0_rf got=%h exp=0", rf[0]); end
  endtask

  task automatic test_collision();
    alloc_en = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_en = 1'b0;
    req_valid = 3'b001; req_rd[0] = 5'd7; req_data[0] = 32'h77;
    tick();
    req_valid = '0;
    checks++; if ({wb_we, wb_a3} !== {1'b1, 5'd7}) begin failures++; $display("FAIL coll_wb got=%0b/%0d exp=1/7", wb_we, wb_a3); end
    alloc_en = 1'b1; alloc_rd = 5'd7;
    tick();
    alloc_en = 1'b0;
    checks++; if (busy[7] !== 1'b1) begin failures++; $display("FAIL coll_busy got=%0b exp=1", busy[7]); end
    tick();
    checks++; if (busy !== (32'h1 << 7)) begin failures++; $display("FAIL coll_busy_hold got=%h exp=%h", busy, 32'h1 << 7); end
  endtask

  task automatic test_reset_mid();
    alloc_en = 1'b1; alloc_rd = 5'd9;
    req_valid = 3'b001; req_rd[0] = 5'd9; req_data[0] = 32'h99;
    tick();
    alloc_en = 1'b0;
    req_valid = '0;
    checks++; if (wb_we !== 1'b1) begin failures++; $display("FAIL mid_granted got=%0b exp=1", wb_we); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b0, 5'd0, 32'h0}) begin
      failures++; $display("FAIL mid_wb got=%0b/%0d/%h exp=0/0/0", wb_we, wb_a3, wb_wd3);
    end
    checks++; if (busy !== '0) begin failures++; $display("FAIL mid_busy got=%h exp=0", busy); end
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL mid_first got=%b exp=001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] vals [3];
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3;
    req_valid = 3'b001; req_rd[0] = 5'd3;
    for (int i = 0; i < 3; i++) begin
      req_data[0] = vals[i];
      tick();
      checks++; if ({wb_we, wb_a3, wb_wd3} !== {1'b1, 5'd3, vals[i]}) begin
        failures++; $display("FAIL b2b_wb%0d got=%0b/%0d/%h exp=1/3/%h", i, wb_we, wb_a3, wb_wd3, vals[i]);
      end
    end
    req_valid = '0;
    tick();
    checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0b exp=0", wb_we); end
    checks++; if (rf[3] !== 32'd3) begin failures++; $display("FAIL b2b_rf got=%h exp=3", rf[3]); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
